// File: rtl/receptor_pkg.sv
// Shared types and codes for the four-phase receptor link.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package receptor_pkg;

  // Handshake FSM states; ack is decoded directly from these.
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  localparam logic [1:0] SEND_IDLE = 2'b00;
  localparam logic [1:0] SEND_REQ  = 2'b01;
  localparam logic [1:0] ACK_IDLE  = 2'b00;
  localparam logic [1:0] ACK_OK    = 2'b01;

  // Codes 2'b10 and 2'b11 are reserved; both have the upper bit set.
  function automatic logic is_reserved(input logic [1:0] code);
    return code[1];
  endfunction

endpackage

// File: rtl/receptor_fifo.sv
// Circular FIFO holding accepted words for the downstream consumer.
// Latency: a write is visible at the head one cycle after its edge (no bypass).
// Backpressure: writes while full and reads while empty are ignored.
module receptor_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage is deliberately left unreset; head is don't-care while empty.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fsm_receptor.sv
// Four-phase handshake receiver feeding a FIFO towards a valid/ready consumer.
// Latency: ack rises the cycle after the accepting edge; word reaches out_data one cycle after write.
// Backpressure: a full FIFO holds the FSM in IDLE so the upstream request simply waits.
module fsm_receptor
  import receptor_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               send,
  input  logic [DATA_W-1:0]        dado,
  output logic [1:0]               ack,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     proto_err
);

  state_t state;
  state_t state_nxt;
  logic   wr_en;
  logic   full;
  logic   empty;
  logic   is_req;

  // Reserved codes never count as a request.
  assign is_req = (send == SEND_REQ);

  // State register; reset abandons any handshake in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and the single write strobe per handshake.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    unique case (state)
      IDLE: begin
        if (is_req && !full) begin
          wr_en     = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (!is_req) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Moore acknowledge taken straight from the state register.
  always_comb begin
    ack = (state == ACK) ? ACK_OK : ACK_IDLE;
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err <= 1'b0;
    end else if (is_reserved(send)) begin
      proto_err <= 1'b1;
    end
  end

  assign out_valid = !empty;

  receptor_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (dado),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_fsm_receptor.sv
// Bench for fsm_receptor: directed scenarios plus a randomized run against a queue model.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: consumer ready is driven low, high, toggling or random per scenario.
module tb_fsm_receptor;

  localparam int DW = 16;
  localparam int DP = 4;

  logic          clk;
  logic          rst;
  logic [1:0]    send;
  logic [DW-1:0] dado;
  logic [1:0]    ack;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    count;
  logic          proto_err;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: stored words, handshake-in-progress flag, sticky error.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_pop[$];
  logic [DW-1:0] seen[$];
  bit            m_busy;
  bit            m_perr;
  bit            tog;

  fsm_receptor #(.DATA_W(DW), .DEPTH(DP)) dut (
    .clk       (clk),
    .rst       (rst),
    .send      (send),
    .dado      (dado),
    .ack       (ack),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock: apply inputs, advance the model by the protocol rules, settle.
  task automatic tick(input logic [1:0] s, input logic [DW-1:0] d, input logic r);
    bit wr, rd;
    send = s; dado = d; out_ready = r;
    wr = !m_busy && (s == 2'b01) && (m_q.size() < DP);
    rd = (m_q.size() > 0) && r;
    if (out_valid === 1'b1 && r) seen.push_back(out_data);
    @(posedge clk);
    if (rd) m_pop.push_back(m_q.pop_front());
    if (wr) m_q.push_back(d);
    if (s[1]) m_perr = 1'b1;
    if (wr) m_busy = 1'b1;
    else if (s != 2'b01) m_busy = 1'b0;
    #1;
  endtask

  task automatic model_clear();
    m_q.delete(); m_pop.delete(); seen.delete();
    m_busy = 1'b0; m_perr = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; send = 2'b00; dado = '0; out_ready = 1'b0;
    #3;
    rst = 1'b0;
    model_clear();
    @(posedge clk); #1;
  endtask

  // Full four-phase handshake; rmode 0=ready low, 1=ready high, 2=toggling.
  task automatic handshake(input logic [DW-1:0] w, input int rmode);
    int k;
    logic r;
    k = 0;
    do begin
      r = (rmode == 0) ? 1'b0 : (rmode == 1) ? 1'b1 : tog;
      tog = ~tog;
      tick(2'b01, w, r);
      k++;
    end while (ack !== 2'b01 && k < 40);
    n_cmp++;
    if (ack !== 2'b01) begin n_fail++; $display("FAIL hs_ack_rise: ack=%b want 01 (word %h)", ack, w); end
    k = 0;
    do begin
      r = (rmode == 0) ? 1'b0 : (rmode == 1) ? 1'b1 : tog;
      tog = ~tog;
      tick(2'b00, w, r);
      k++;
    end while (ack !== 2'b00 && k < 40);
    n_cmp++;
    if (ack !== 2'b00) begin n_fail++; $display("FAIL hs_ack_fall: ack=%b want 00 (word %h)", ack, w); end
  endtask

  task automatic test_reset();
    rst = 1'b1; send = 2'b00; dado = '0; out_ready = 1'b0;
    #1;
    n_cmp++; if (ack !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b want 00", ack); end
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", proto_err); end
    #3;
    rst = 1'b0;
    model_clear();
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    apply_reset();
    tick(2'b01, 16'hA5A5, 1'b0);
    n_cmp++; if (ack !== 2'b01) begin n_fail++; $display("FAIL single_ack: got %b want 01", ack); end
    n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", count); end
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 16'hA5A5) begin n_fail++; $display("FAIL single_data: got %h want a5a5", out_data); end
    tick(2'b00, 16'h0000, 1'b0);
    n_cmp++; if (ack !== 2'b00) begin n_fail++; $display("FAIL single_ack_fall: got %b want 00", ack); end
    tick(2'b00, 16'h0000, 1'b1);
    n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: count=%0d valid=%b want 0/0", count, out_valid); end
  endtask

  task automatic test_fill();
    apply_reset();
    for (int i = 1; i <= 4; i++) handshake(DW'(i), 0);
    n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d want 4", count); end
    tick(2'b01, 16'h0005, 1'b0);
    n_cmp++; if (ack !== 2'b00 || count !== 3'd4) begin n_fail++; $display("FAIL fill_stall: ack=%b count=%0d want 00/4", ack, count); end
    tick(2'b01, 16'h0005, 1'b1);
    n_cmp++; if (ack !== 2'b00 || count !== 3'd3) begin n_fail++; $display("FAIL fill_read_no_write: ack=%b count=%0d want 00/3", ack, count); end
    n_cmp++; if (seen.size() != 1 || seen[0] !== 16'h0001) begin n_fail++; $display("FAIL fill_first_out: got %0d words want 0001 first", seen.size()); end
    n_cmp++; if (out_data !== 16'h0002) begin n_fail++; $display("FAIL fill_head: got %h want 0002", out_data); end
    tick(2'b01, 16'h0005, 1'b0);
    n_cmp++; if (ack !== 2'b01 || count !== 3'd4) begin n_fail++; $display("FAIL fill_fifth: ack=%b count=%0d want 01/4", ack, count); end
    tick(2'b00, 16'h0005, 1'b0);
    for (int k = 0; k < 10 && out_valid === 1'b1; k++) begin
      n_cmp++; if (out_data !== m_q[0]) begin n_fail++; $display("FAIL fill_drain: got %h want %h", out_data, m_q[0]); end
      tick(2'b00, 16'h0000, 1'b1);
    end
    n_cmp++; if (m_pop.size() != 5 || m_pop[4] !== 16'h0005 || count !== 3'd0) begin n_fail++; $display("FAIL fill_total: popped=%0d count=%0d want 5/0", m_pop.size(), count); end
  endtask

  task automatic test_order_wrap();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      handshake(16'h0010 + DW'(i), 2);
      n_cmp++; if (count !== 3'(m_q.size()) || count > 3'd4) begin n_fail++; $display("FAIL order_count: got %0d want %0d", count, m_q.size()); end
    end
    for (int k = 0; k < 20 && out_valid === 1'b1; k++) tick(2'b00, 16'h0000, 1'b1);
    n_cmp++; if (seen.size() != 10) begin n_fail++; $display("FAIL order_len: got %0d want 10", seen.size()); end
    for (int i = 0; i < 10 && i < seen.size(); i++) begin
      n_cmp++; if (seen[i] !== 16'h0010 + DW'(i)) begin n_fail++; $display("FAIL order_word%0d: got %h want %h", i, seen[i], 16'h0010 + DW'(i)); end
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    handshake(16'h0021, 0);
    handshake(16'h0022, 0);
    n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL simul_pre: got %0d want 2", count); end
    tick(2'b01, 16'h0023, 1'b1);
    n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL simul_count: got %0d want 2", count); end
    n_cmp++; if (out_data !== 16'h0022 || ack !== 2'b01) begin n_fail++; $display("FAIL simul_head: data=%h ack=%b want 0022/01", out_data, ack); end
    tick(2'b00, 16'h0000, 1'b0);
  endtask

  task automatic test_proto_err();
    apply_reset();
    tick(2'b11, 16'hBEEF, 1'b0);
    n_cmp++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL perr_set: got %b want 1", proto_err); end
    n_cmp++; if (count !== 3'd0 || ack !== 2'b00) begin n_fail++; $display("FAIL perr_nowrite: count=%0d ack=%b want 0/00", count, ack); end
    tick(2'b00, 16'h0000, 1'b0);
    tick(2'b01, 16'h0044, 1'b0);
    tick(2'b10, 16'h0044, 1'b0);
    n_cmp++; if (ack !== 2'b00 || count !== 3'd1) begin n_fail++; $display("FAIL perr_in_ack: ack=%b count=%0d want 00/1", ack, count); end
    tick(2'b00, 16'h0000, 1'b0);
    n_cmp++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL perr_sticky: got %b want 1", proto_err); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    handshake(16'h0031, 0);
    handshake(16'h0032, 0);
    tick(2'b01, 16'h0033, 1'b0);
    tick(2'b01, 16'h0033, 1'b0);
    n_cmp++; if (ack !== 2'b01 || count !== 3'd3) begin n_fail++; $display("FAIL arst_pre: ack=%b count=%0d want 01/3", ack, count); end
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (ack !== 2'b00 || count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_immediate: ack=%b count=%0d valid=%b want 00/0/0", ack, count, out_valid); end
    #1 rst = 1'b0;
    model_clear();
    tick(2'b01, 16'h0077, 1'b0);
    n_cmp++; if (ack !== 2'b01 || count !== 3'd1 || out_data !== 16'h0077) begin n_fail++; $display("FAIL arst_new_req: ack=%b count=%0d data=%h want 01/1/0077", ack, count, out_data); end
    tick(2'b00, 16'h0000, 1'b0);
  endtask

  task automatic test_random();
    int phase;
    logic [1:0] s;
    logic [DW-1:0] w;
    apply_reset();
    phase = 0;
    w = DW'($urandom);
    for (int i = 0; i < 600; i++) begin
      s = 2'b00;
      if (phase == 1) s = 2'b01;
      else if (phase == 0 && $urandom_range(0, 59) == 0) s = 2'b10;
      tick(s, w, 1'($urandom_range(0, 1)));
      n_cmp++; if (ack !== (m_busy ? 2'b01 : 2'b00)) begin n_fail++; $display("FAIL rnd_ack@%0d: got %b want %b", i, ack, m_busy ? 2'b01 : 2'b00); end
      n_cmp++; if (count !== 3'(m_q.size())) begin n_fail++; $display("FAIL rnd_count@%0d: got %0d want %0d", i, count, m_q.size()); end
      n_cmp++; if (out_valid !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b", i, out_valid); end
      if (m_q.size() > 0) begin
        n_cmp++; if (out_data !== m_q[0]) begin n_fail++; $display("FAIL rnd_data@%0d: got %h want %h", i, out_data, m_q[0]); end
      end
      n_cmp++; if (proto_err !== m_perr) begin n_fail++; $display("FAIL rnd_perr@%0d: got %b want %b", i, proto_err, m_perr); end
      if (phase == 0 && $urandom_range(0, 2) == 0) phase = 1;
      else if (phase == 1 && ack === 2'b01) phase = 2;
      else if (phase == 2 && ack === 2'b00) begin phase = 0; w = DW'($urandom); end
    end
    n_cmp++; if (seen.size() != m_pop.size()) begin n_fail++; $display("FAIL rnd_out_len: got %0d want %0d", seen.size(), m_pop.size()); end
    for (int i = 0; i < seen.size() && i < m_pop.size(); i++) begin
      if (seen[i] !== m_pop[i]) begin
        n_cmp++; n_fail++;
        $display("FAIL rnd_out_order%0d: got %h want %h", i, seen[i], m_pop[i]);
      end
    end
  endtask

  initial begin
    tog = 1'b0;
    m_busy = 1'b0;
    m_perr = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_order_wrap();
    test_simultaneous();
    test_proto_err();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_receptor.md
FSM_RECEPTOR -- requirements
Module: fsm_receptor

Interface
REQ-001 Parameter DATA_W, default 16, width of the data word on both ports.
REQ-002 Parameter DEPTH, default 4, number of FIFO entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 send  input  2  request from upstream processor FSM: 2'b00 idle, 2'b01 request, 2'b10/2'b11 reserved.
REQ-006 dado  input  DATA_W  data word; valid while send==2'b01.
REQ-007 ack  output  2  acknowledge to upstream: 2'b00 idle, 2'b01 word accepted.
REQ-008 out_data  output  DATA_W  head-of-FIFO word to downstream consumer.
REQ-009 out_valid  output  1  high when FIFO is non-empty.
REQ-010 out_ready  input  1  consumer accepts out_data when out_valid && out_ready at a rising edge.
REQ-011 count  output  $clog2(DEPTH)+1  number of words currently stored.
REQ-012 proto_err  output  1  sticky flag: reserved send code observed.

Function
REQ-013 Upstream link SHALL be a four-phase handshake: request 01 -> ack 01 -> send 00 -> ack 00.
REQ-014 FSM SHALL have states IDLE (ack=00) and ACK (ack=01); ack is a registered Moore output of state.
REQ-015 In IDLE with send==01 and count<DEPTH, the edge SHALL write dado into FIFO and move to ACK; ack reads 01 from the next cycle.
REQ-016 In IDLE with send==01 and count==DEPTH, FSM SHALL stay in IDLE and write nothing (upstream stalls), independent of a same-cycle read.
REQ-017 In ACK, FSM SHALL stay in ACK while send!=00 and SHALL NOT write again; on send==00 it SHALL return to IDLE (ack 00 next cycle).
REQ-018 Exactly one FIFO write SHALL occur per completed handshake; minimum handshake period is 2 cycles of ack activity.
REQ-019 send of 2'b10 or 2'b11 in any state SHALL set proto_err and SHALL otherwise be treated as 00 (not a request).
REQ-020 A read SHALL occur on an edge with out_valid && out_ready; read pointer advances, count decrements.
REQ-021 Simultaneous accepted write and read SHALL leave count unchanged.
REQ-022 No bypass: word written into an empty FIFO SHALL appear on out_data/out_valid one cycle after the write edge.
REQ-023 out_data SHALL be the FIFO head, held stable while out_valid && !out_ready.
REQ-024 out_ready while empty SHALL have no effect; count SHALL never underflow or exceed DEPTH.
REQ-025 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.

Reset
REQ-026 rst high SHALL immediately force state IDLE, ack=00, count=0, pointers=0, out_valid=0, proto_err=0.
REQ-027 out_data after reset is don't-care while out_valid=0; FIFO storage SHALL NOT be reset.
REQ-028 Reset mid-handshake SHALL abandon it; after release a still-asserted send==01 SHALL be treated as a new request.

Structure
REQ-029 Package receptor_pkg SHALL hold the state enum {IDLE, ACK} and constants SEND_IDLE=2'b00, SEND_REQ=2'b01, ACK_IDLE=2'b00, ACK_OK=2'b01.
REQ-030 Storage SHALL be one sub-module receptor_fifo (synchronous write/read, count, full/empty); handshake FSM in fsm_receptor.

Verification
REQ-031 Single transfer: send=01,dado=16'hA5A5 -> ack=01 next cycle, count=1, out_data=16'hA5A5,out_valid=1; send=00 -> ack=00.
REQ-032 Fill: out_ready=0, four handshakes 16'h0001..16'h0004 -> count=4; fifth request (16'h0005) -> ack stays 00, count 4; out_ready=1 one cycle -> 16'h0001 leaves, then fifth handshake completes.
REQ-033 Order/wrap: 10 words 16'h0010..16'h0019 with out_ready toggling -> consumer sees all ten in order, count never >4.
REQ-034 Simultaneous: count=2, accepted write and read on same edge -> count stays 2, head advances.
REQ-035 Protocol error: send=2'b11 one cycle -> proto_err=1, no write, ack 00; stays 1 until rst.
REQ-036 Async reset: assert rst mid-cycle in ACK with count=3 -> ack=00, count=0, out_valid=0 before next clk edge.
